// File: rtl/soin_bpredictor_resolve_pkg.sv
// Shared definitions for the bimodal predictor resolve path.
// Holds the prediction-metadata field layout, the 2-bit counter saturation
// limits, the branch-class encoding and the counter step helper. The same
// layout is used by the predict side when it builds the metadata.
package soin_bpredictor_resolve_pkg;

   // Metadata layout: [11:0] table index, [13:12] counter, [17:14] RAS
   // index, [21:18] reserved (always written as zero).
   localparam int BP_IDX_LSB = 0;
   localparam int BP_IDX_W   = 12;
   localparam int BP_CTR_LSB = 12;
   localparam int BP_CTR_W   = 2;
   localparam int BP_RAS_LSB = 14;
   localparam int BP_RAS_W   = 4;
   localparam int BP_RSV_LSB = 18;
   localparam int BP_RSV_W   = 4;

   // Saturation limits of the 2-bit direction counter.
   localparam logic [BP_CTR_W-1:0] CTR_MIN = 2'd0;
   localparam logic [BP_CTR_W-1:0] CTR_MAX = 2'd3;

   // Branch classes as seen by the resolve logic.
   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_COND = 2'd1,
      BR_CALL = 2'd2,
      BR_RET  = 2'd3
   } br_class_e;

   // Collapse the three one-hot class flags into an encoded class.
   function automatic br_class_e classify(input logic is_cond,
                                          input logic is_call,
                                          input logic is_ret);
      br_class_e c;
      c = BR_NONE;
      if (is_cond)
         c = BR_COND;
      else if (is_call)
         c = BR_CALL;
      else if (is_ret)
         c = BR_RET;
      return c;
   endfunction

   // Saturating step of the direction counter towards the actual outcome.
   function automatic logic [BP_CTR_W-1:0] ctr_next(input logic [BP_CTR_W-1:0] base,
                                                    input logic taken);
      logic [BP_CTR_W-1:0] n;
      n = base;
      if (taken && base != CTR_MAX)
         n = base + 2'd1;
      else if (!taken && base != CTR_MIN)
         n = base - 2'd1;
      return n;
   endfunction

endpackage

// File: rtl/soin_bpredictor_update_fifo.sv
// Small synchronous FIFO holding pending predictor table writes.
// Ports:
//   clk, reset     clock, asynchronous active-high reset (clears pointers)
//   push, pop      write / read strobes; a push while full is only taken
//                  when a pop happens on the same edge
//   din            entry to enqueue
//   head           oldest entry, combinational from storage
//   full, empty    occupancy flags
module soin_bpredictor_update_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   // when the slot bits are equal.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   // Pointer registers; reset empties the queue without touching storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write. When full with a simultaneous pop, the write lands in
   // the slot being vacated, which is safe because head is read before the edge.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/soin_bpredictor_resolve.sv
// Execute-side resolve stage of the bimodal branch predictor.
// Compares each resolved branch with the prediction fetch attached, raises
// a registered fetch redirect and RAS recovery pulse on a mispredict, and
// queues the saturating-counter write-back for the predictor table.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   res_*                      resolved branch from execute plus fetch metadata
//   soin_bpredictor_stall      predictor cannot take a table write this cycle
//   fetch_redirect(_PC)        one-cycle redirect pulse and correct next PC
//   execute_bpredictor_*       table write bus driven from the queue head
//   execute_bpredictor_recover_ras  RAS restore pulse, index in meta[17:14]
//   drop_count                 saturating count of updates lost to a full queue
module soin_bpredictor_resolve
   import soin_bpredictor_resolve_pkg::*;
#(
   parameter int BP_META_WIDTH = 22,
   parameter int FIFO_DEPTH    = 4,
   parameter int BYP_DEPTH     = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     res_valid,
   input  logic [31:0]              res_PC,
   input  logic                     res_is_cond,
   input  logic                     res_is_call,
   input  logic                     res_is_ret,
   input  logic                     res_dir,
   input  logic [31:0]              res_target,
   input  logic                     res_p_dir,
   input  logic [31:0]              res_p_target,
   input  logic [BP_META_WIDTH-1:0] res_meta,
   input  logic                     soin_bpredictor_stall,
   output logic                     fetch_redirect,
   output logic [31:0]              fetch_redirect_PC,
   output logic                     execute_bpredictor_update,
   output logic [31:0]              execute_bpredictor_PC,
   output logic [31:0]              execute_bpredictor_target,
   output logic                     execute_bpredictor_dir,
   output logic                     execute_bpredictor_miss,
   output logic [BP_META_WIDTH-1:0] execute_bpredictor_meta,
   output logic                     execute_bpredictor_recover_ras,
   output logic [15:0]              drop_count
);

   localparam int ENTRY_W = 32 + 32 + 1 + 1 + BP_META_WIDTH;

   logic                     miss;
   logic                     res_upd;
   br_class_e                res_class;
   logic [BP_IDX_W-1:0]      res_idx;
   logic [BP_CTR_W-1:0]      base_ctr;
   logic [BP_CTR_W-1:0]      new_ctr;
   logic [BP_RAS_W-1:0]      ras_idx_new;
   logic [BP_META_WIDTH-1:0] new_meta;

   logic                     s1_valid;
   logic [ENTRY_W-1:0]       s1_entry;
   logic [BP_RAS_W-1:0]      s1_ras_idx;

   logic [BYP_DEPTH-1:0]     byp_valid;
   logic [BYP_DEPTH-1:0]     byp_live;
   logic [BP_IDX_W-1:0]      byp_idx [BYP_DEPTH];
   logic [BP_CTR_W-1:0]      byp_ctr [BYP_DEPTH];

   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     push;
   logic                     pop;
   logic                     drop;
   logic [ENTRY_W-1:0]       head;
   logic [ENTRY_W-1:0]       head_view;
   logic [BP_META_WIDTH-1:0] head_meta;

   logic                     unused_rsv_bits;

   assign res_idx   = res_meta[BP_IDX_LSB +: BP_IDX_W];
   assign res_class = classify(res_is_cond, res_is_call, res_is_ret);
   assign res_upd   = res_valid && (res_class != BR_NONE);
   assign miss      = (res_p_dir != res_dir) || (res_dir && (res_p_target != res_target));

   assign unused_rsv_bits = ^res_meta[BP_META_WIDTH-1:BP_RSV_LSB];

   // Queue handshake. The stage-1 entry is lost only when the queue is full
   // and the head is not leaving on this same edge.
   assign pop  = !fifo_empty && !soin_bpredictor_stall;
   assign drop = s1_valid && fifo_full && !pop;
   assign push = s1_valid && !drop;

   // The newest bypass slot always belongs to the entry currently sitting in
   // stage 1, so if that entry is being dropped it must stop forwarding now.
   always_comb begin
      byp_live = byp_valid;
      if (drop)
         byp_live[0] = 1'b0;
   end

   // Counter base selection: scan oldest to newest so the newest matching
   // bypass slot wins, falling back to the counter fetch read.
   always_comb begin
      base_ctr = res_meta[BP_CTR_LSB +: BP_CTR_W];
      for (int i = BYP_DEPTH-1; i >= 0; i--) begin
         if (byp_live[i] && (byp_idx[i] == res_idx))
            base_ctr = byp_ctr[i];
      end
   end

   // New counter, restored RAS index and the repacked metadata for the write.
   always_comb begin
      new_ctr     = ctr_next(base_ctr, res_dir);
      ras_idx_new = res_meta[BP_RAS_LSB +: BP_RAS_W];
      case (res_class)
         BR_CALL: ras_idx_new = res_meta[BP_RAS_LSB +: BP_RAS_W] + 4'd1;
         BR_RET:  ras_idx_new = res_meta[BP_RAS_LSB +: BP_RAS_W] - 4'd1;
         default: ras_idx_new = res_meta[BP_RAS_LSB +: BP_RAS_W];
      endcase
      new_meta = '0;
      new_meta[BP_IDX_LSB +: BP_IDX_W] = res_idx;
      new_meta[BP_CTR_LSB +: BP_CTR_W] = new_ctr;
      new_meta[BP_RAS_LSB +: BP_RAS_W] = ras_idx_new;
   end

   // Stage-1 register: redirect and RAS pulse leave from here directly, the
   // table update waits here for one cycle before entering the queue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid                       <= 1'b0;
         s1_entry                       <= '0;
         s1_ras_idx                     <= '0;
         fetch_redirect                 <= 1'b0;
         fetch_redirect_PC              <= '0;
         execute_bpredictor_recover_ras <= 1'b0;
      end else begin
         s1_valid                       <= res_upd;
         s1_entry                       <= {res_PC, res_target, res_dir, miss, new_meta};
         s1_ras_idx                     <= ras_idx_new;
         fetch_redirect                 <= res_valid && miss;
         fetch_redirect_PC              <= res_dir ? res_target : (res_PC + 32'd4);
         execute_bpredictor_recover_ras <= res_valid && miss;
      end
   end

   // Bypass valid bits: shift in each accepted update newest-first and kill
   // the slot of a stage-1 entry that the queue refused.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byp_valid <= '0;
      end else if (res_upd) begin
         for (int i = BYP_DEPTH-1; i > 0; i--)
            byp_valid[i] <= byp_live[i-1];
         byp_valid[0] <= 1'b1;
      end else begin
         byp_valid <= byp_live;
      end
   end

   // Bypass payload shifts alongside the valid bits; it needs no reset.
   always_ff @(posedge clk) begin
      if (res_upd) begin
         for (int i = BYP_DEPTH-1; i > 0; i--) begin
            byp_idx[i] <= byp_idx[i-1];
            byp_ctr[i] <= byp_ctr[i-1];
         end
         byp_idx[0] <= res_idx;
         byp_ctr[0] <= new_ctr;
      end
   end

   // Lost-update counter, held at its maximum once saturated.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         drop_count <= '0;
      else if (drop && (drop_count != 16'hFFFF))
         drop_count <= drop_count + 16'd1;
   end

   soin_bpredictor_update_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (s1_entry),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Write bus is driven from the queue head and held at zero when empty.
   always_comb begin
      head_view = head;
      if (fifo_empty)
         head_view = '0;
   end

   assign execute_bpredictor_update = pop;
   assign {execute_bpredictor_PC, execute_bpredictor_target,
           execute_bpredictor_dir, execute_bpredictor_miss, head_meta} = head_view;

   // During a recovery pulse the RAS field shows the index of the branch that
   // caused it, which may not be the entry at the head of the queue.
   always_comb begin
      execute_bpredictor_meta = head_meta;
      if (execute_bpredictor_recover_ras)
         execute_bpredictor_meta[BP_RAS_LSB +: BP_RAS_W] = s1_ras_idx;
   end

endmodule

// File: tb/tb_soin_bpredictor_resolve.sv
// Self-checking bench for soin_bpredictor_resolve: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_soin_bpredictor_resolve;

   localparam int MW    = 22;
   localparam int DEPTH = 4;
   localparam int BYP   = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          res_valid;
   logic [31:0]   res_PC;
   logic          res_is_cond;
   logic          res_is_call;
   logic          res_is_ret;
   logic          res_dir;
   logic [31:0]   res_target;
   logic          res_p_dir;
   logic [31:0]   res_p_target;
   logic [MW-1:0] res_meta;
   logic          soin_bpredictor_stall;
   logic          fetch_redirect;
   logic [31:0]   fetch_redirect_PC;
   logic          execute_bpredictor_update;
   logic [31:0]   execute_bpredictor_PC;
   logic [31:0]   execute_bpredictor_target;
   logic          execute_bpredictor_dir;
   logic          execute_bpredictor_miss;
   logic [MW-1:0] execute_bpredictor_meta;
   logic          execute_bpredictor_recover_ras;
   logic [15:0]   drop_count;

   always #5 clk = ~clk;

   soin_bpredictor_resolve #(
      .BP_META_WIDTH (MW),
      .FIFO_DEPTH    (DEPTH),
      .BYP_DEPTH     (BYP)
   ) dut (
      .clk                            (clk),
      .reset                          (reset),
      .res_valid                      (res_valid),
      .res_PC                         (res_PC),
      .res_is_cond                    (res_is_cond),
      .res_is_call                    (res_is_call),
      .res_is_ret                     (res_is_ret),
      .res_dir                        (res_dir),
      .res_target                     (res_target),
      .res_p_dir                      (res_p_dir),
      .res_p_target                   (res_p_target),
      .res_meta                       (res_meta),
      .soin_bpredictor_stall          (soin_bpredictor_stall),
      .fetch_redirect                 (fetch_redirect),
      .fetch_redirect_PC              (fetch_redirect_PC),
      .execute_bpredictor_update      (execute_bpredictor_update),
      .execute_bpredictor_PC          (execute_bpredictor_PC),
      .execute_bpredictor_target      (execute_bpredictor_target),
      .execute_bpredictor_dir         (execute_bpredictor_dir),
      .execute_bpredictor_miss        (execute_bpredictor_miss),
      .execute_bpredictor_meta        (execute_bpredictor_meta),
      .execute_bpredictor_recover_ras (execute_bpredictor_recover_ras),
      .drop_count                     (drop_count)
   );

   int checkCount = 0;
   int passCount  = 0;

   // Single comparison point: counts, and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   // Reference model state: expected registered outputs, the update waiting
   // to enter the queue, the queue itself and the recent-write history.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] target;
      logic        dir;
      logic        miss;
      logic [21:0] meta;
   } upd_t;

   typedef struct {
      int idx;
      int ctr;
      bit live;
   } byp_t;

   upd_t        mq[$];
   upd_t        mPend;
   bit          mPendValid;
   byp_t        mByp[$];
   bit          mRedirect;
   bit          mRecover;
   logic [31:0] mRedirectPc;
   logic [3:0]  mRas;
   int          mDrops;

   task automatic modelClear();
      mq.delete();
      mByp.delete();
      mPendValid  = 0;
      mRedirect   = 0;
      mRecover    = 0;
      mRedirectPc = '0;
      mRas        = '0;
      mDrops      = 0;
   endtask

   task automatic applyStimulus(input bit v, input logic [31:0] pc, input int cls,
                                input bit dir, input logic [31:0] tgt,
                                input bit pdir, input logic [31:0] ptgt,
                                input int idx, input int ctr, input int ras,
                                input bit stall);
      res_valid             = v;
      res_PC                = pc;
      res_is_cond           = (cls == 1);
      res_is_call           = (cls == 2);
      res_is_ret            = (cls == 3);
      res_dir               = dir;
      res_target            = tgt;
      res_p_dir             = pdir;
      res_p_target          = ptgt;
      res_meta              = {4'b0, ras[3:0], ctr[1:0], idx[11:0]};
      soin_bpredictor_stall = stall;
      #1;
   endtask

   task automatic applyIdle(input bit stall);
      applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, stall);
   endtask

   // Compare every output with the model, then advance the model across the
   // coming clock edge using the inputs currently driven.
   task automatic cycle();
      bit          expUpd;
      bit          pop;
      bit          drop;
      bit          mis;
      int          idx;
      int          base;
      int          nc;
      logic [21:0] expMeta;
      logic [3:0]  ras;
      upd_t        u;
      #1;
      checkOutput("redirect", {31'b0, fetch_redirect}, {31'b0, mRedirect});
      if (mRedirect)
         checkOutput("redirect_pc", fetch_redirect_PC, mRedirectPc);
      checkOutput("recover_ras", {31'b0, execute_bpredictor_recover_ras}, {31'b0, mRecover});
      expUpd = (mq.size() > 0) && !soin_bpredictor_stall;
      checkOutput("update", {31'b0, execute_bpredictor_update}, {31'b0, expUpd});
      if (mq.size() > 0) begin
         checkOutput("upd_pc", execute_bpredictor_PC, mq[0].pc);
         checkOutput("upd_target", execute_bpredictor_target, mq[0].target);
         checkOutput("upd_dir", {31'b0, execute_bpredictor_dir}, {31'b0, mq[0].dir});
         checkOutput("upd_miss", {31'b0, execute_bpredictor_miss}, {31'b0, mq[0].miss});
         expMeta = mq[0].meta;
         if (mRecover)
            expMeta[17:14] = mRas;
         checkOutput("upd_meta", {10'b0, execute_bpredictor_meta}, {10'b0, expMeta});
      end else if (mRecover) begin
         ras = execute_bpredictor_meta[17:14];
         checkOutput("ras_idx", {28'b0, ras}, {28'b0, mRas});
      end
      checkOutput("drop_count", {16'b0, drop_count}, mDrops);

      pop  = (mq.size() > 0) && !soin_bpredictor_stall;
      drop = mPendValid && (mq.size() == DEPTH) && !pop;
      if (drop)
         mByp[0].live = 0;
      idx  = int'(res_meta[11:0]);
      base = int'(res_meta[13:12]);
      foreach (mByp[i]) begin
         if (mByp[i].live && mByp[i].idx == idx) begin
            base = mByp[i].ctr;
            break;
         end
      end
      if (pop)
         void'(mq.pop_front());
      if (mPendValid) begin
         if (drop)
            mDrops = (mDrops == 65535) ? 65535 : mDrops + 1;
         else
            mq.push_back(mPend);
      end
      mis         = (res_p_dir != res_dir) || (res_dir && res_p_target != res_target);
      mRedirect   = res_valid && mis;
      mRecover    = res_valid && mis;
      mRedirectPc = res_dir ? res_target : res_PC + 32'd4;
      ras         = res_meta[17:14];
      if (res_is_call)
         ras = ras + 4'd1;
      else if (res_is_ret)
         ras = ras - 4'd1;
      mRas = ras;
      if (res_valid && (res_is_cond || res_is_call || res_is_ret)) begin
         nc       = res_dir ? ((base + 1 > 3) ? 3 : base + 1) : ((base - 1 < 0) ? 0 : base - 1);
         u.pc     = res_PC;
         u.target = res_target;
         u.dir    = res_dir;
         u.miss   = mis;
         u.meta   = {4'b0, ras, nc[1:0], res_meta[11:0]};
         mPend      = u;
         mPendValid = 1;
         mByp.push_front('{idx, nc, 1'b1});
         if (mByp.size() > BYP)
            void'(mByp.pop_back());
      end else begin
         mPendValid = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyIdle(0);
         cycle();
      end
   endtask

   // Asynchronous reset in the middle of a cycle: outputs must drop at once.
   task automatic doReset();
      reset = 1'b1;
      #1;
      checkOutput("rst_redirect", {31'b0, fetch_redirect}, 32'd0);
      checkOutput("rst_redirect_pc", fetch_redirect_PC, 32'd0);
      checkOutput("rst_update", {31'b0, execute_bpredictor_update}, 32'd0);
      checkOutput("rst_recover", {31'b0, execute_bpredictor_recover_ras}, 32'd0);
      checkOutput("rst_meta", {10'b0, execute_bpredictor_meta}, 32'd0);
      checkOutput("rst_pc", execute_bpredictor_PC, 32'd0);
      checkOutput("rst_drop", {16'b0, drop_count}, 32'd0);
      modelClear();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      modelClear();
      reset = 1'b1;
      applyIdle(0);
      #2;
      checkOutput("init_redirect", {31'b0, fetch_redirect}, 32'd0);
      checkOutput("init_update", {31'b0, execute_bpredictor_update}, 32'd0);
      checkOutput("init_recover", {31'b0, execute_bpredictor_recover_ras}, 32'd0);
      checkOutput("init_drop", {16'b0, drop_count}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idleCycles(2);

      // Mispredicted taken conditional branch.
      applyStimulus(1, 32'h1000, 1, 1, 32'h1040, 0, 32'h0, 12'h400, 1, 0, 0);
      cycle();
      applyIdle(0);
      checkOutput("tp1_redirect", {31'b0, fetch_redirect}, 32'd1);
      checkOutput("tp1_redirect_pc", fetch_redirect_PC, 32'h1040);
      checkOutput("tp1_recover", {31'b0, execute_bpredictor_recover_ras}, 32'd1);
      cycle();
      applyIdle(0);
      checkOutput("tp1_update", {31'b0, execute_bpredictor_update}, 32'd1);
      checkOutput("tp1_ctr", {30'b0, execute_bpredictor_meta[13:12]}, 32'd2);
      checkOutput("tp1_miss", {31'b0, execute_bpredictor_miss}, 32'd1);
      cycle();
      idleCycles(2);

      // Correctly predicted not-taken, counter already at the floor.
      applyStimulus(1, 32'h2000, 1, 0, 32'h2080, 0, 32'h2080, 12'h200, 0, 0, 0);
      cycle();
      applyIdle(0);
      checkOutput("tp2_redirect", {31'b0, fetch_redirect}, 32'd0);
      cycle();
      applyIdle(0);
      checkOutput("tp2_update", {31'b0, execute_bpredictor_update}, 32'd1);
      checkOutput("tp2_ctr", {30'b0, execute_bpredictor_meta[13:12]}, 32'd0);
      checkOutput("tp2_miss", {31'b0, execute_bpredictor_miss}, 32'd0);
      cycle();
      idleCycles(2);

      // Back-to-back taken on one index, all carrying the stale counter 0.
      applyStimulus(1, 32'h3000, 1, 1, 32'h3100, 1, 32'h3100, 12'h010, 0, 0, 0);
      cycle();
      applyStimulus(1, 32'h3004, 1, 1, 32'h3100, 1, 32'h3100, 12'h010, 0, 0, 0);
      cycle();
      applyStimulus(1, 32'h3008, 1, 1, 32'h3100, 1, 32'h3100, 12'h010, 0, 0, 0);
      checkOutput("b2b_ctr0", {30'b0, execute_bpredictor_meta[13:12]}, 32'd1);
      cycle();
      applyIdle(0);
      checkOutput("b2b_ctr1", {30'b0, execute_bpredictor_meta[13:12]}, 32'd2);
      cycle();
      applyIdle(0);
      checkOutput("b2b_ctr2", {30'b0, execute_bpredictor_meta[13:12]}, 32'd3);
      cycle();
      idleCycles(2);

      // Six mispredicted resolutions into a stalled predictor.
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1, 32'h4000 + 32'(k * 16), 1, 1, 32'h5000 + 32'(k * 16), 0, 32'h0,
                       12'h100 + k, 1, 0, 1);
         cycle();
      end
      applyIdle(1);
      cycle();
      applyIdle(0);
      checkOutput("stall_drops", {16'b0, drop_count}, 32'd2);
      for (int k = 0; k < 4; k++) begin
         if (k > 0)
            applyIdle(0);
         checkOutput("stall_drain_upd", {31'b0, execute_bpredictor_update}, 32'd1);
         checkOutput("stall_drain_pc", execute_bpredictor_PC, 32'h4000 + 32'(k * 16));
         cycle();
      end
      applyIdle(0);
      checkOutput("stall_drained", {31'b0, execute_bpredictor_update}, 32'd0);
      cycle();
      idleCycles(1);

      // RAS index restore on mispredicted ret and call, with 4-bit wrap.
      applyStimulus(1, 32'h6000, 3, 1, 32'h6100, 1, 32'h6200, 12'h020, 2, 5, 0);
      cycle();
      applyIdle(0);
      checkOutput("ret_recover", {31'b0, execute_bpredictor_recover_ras}, 32'd1);
      checkOutput("ret_ras_idx", {28'b0, execute_bpredictor_meta[17:14]}, 32'd4);
      cycle();
      applyStimulus(1, 32'h6100, 2, 1, 32'h7000, 0, 32'h0, 12'h021, 2, 15, 0);
      cycle();
      applyIdle(0);
      checkOutput("call_recover", {31'b0, execute_bpredictor_recover_ras}, 32'd1);
      checkOutput("call_ras_idx", {28'b0, execute_bpredictor_meta[17:14]}, 32'd0);
      cycle();
      idleCycles(2);

      // Randomized traffic over a few indices so the bypass is exercised.
      for (int n = 0; n < 400; n++) begin
         applyStimulus($urandom_range(0, 9) < 7,
                       {$urandom_range(0, 255), 2'b00},
                       $urandom_range(0, 3),
                       $urandom_range(0, 1),
                       $urandom_range(0, 1) ? 32'h100 : 32'h200,
                       $urandom_range(0, 1),
                       $urandom_range(0, 1) ? 32'h100 : 32'h200,
                       $urandom_range(0, 3),
                       $urandom_range(0, 3),
                       $urandom_range(0, 15),
                       $urandom_range(0, 9) < 3);
         cycle();
      end
      idleCycles(6);

      // Reset with three updates queued and a redirect pending.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 32'h8000 + 32'(k * 4), 1, 1, 32'h9000, 1, 32'h9000, 12'h300 + k, 1, 0, 1);
         cycle();
      end
      applyStimulus(1, 32'h800C, 1, 1, 32'h9100, 0, 32'h0, 12'h303, 1, 0, 1);
      cycle();
      applyIdle(0);
      checkOutput("pre_rst_redirect", {31'b0, fetch_redirect}, 32'd1);
      checkOutput("pre_rst_update", {31'b0, execute_bpredictor_update}, 32'd1);
      doReset();
      for (int k = 0; k < 3; k++) begin
         applyIdle(0);
         checkOutput("post_rst_update", {31'b0, execute_bpredictor_update}, 32'd0);
         checkOutput("post_rst_redirect", {31'b0, fetch_redirect}, 32'd0);
         cycle();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/soin_bpredictor_resolve.md
Name: soin_bpredictor_resolve

Overview:
- Execute-side counterpart of the bimodal predictor. It takes each resolved branch from execute together with the prediction metadata that fetch attached to it.
- It detects mispredictions and drives the fetch redirect. It also produces the RAS recovery pulse and the saturating-counter write-back on the execute_bpredictor_* bus.
- Updates are buffered in a small FIFO, so that predictor stalls never lose a redirect.

Parameters:
- BP_META_WIDTH, 22, prediction metadata width. Layout: [11:0] table index, [13:12] 2-bit counter read at predict time, [17:14] RAS index at predict time, [21:18] reserved (written 0).
- FIFO_DEPTH, 4, number of update-queue entries (power of 2, ≥2).
- BYP_DEPTH, 2, number of recent counter writes kept for same-index bypass.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- res_valid  in  1  execute has a resolved branch this cycle
- res_PC  in  32  branch PC
- res_is_cond / res_is_call / res_is_ret  in  1 each  branch class (mutually exclusive)
- res_dir  in  1  actual direction
- res_target  in  32  actual target (ignored when res_dir=0)
- res_p_dir  in  1  predicted direction
- res_p_target  in  32  predicted target
- res_meta  in  BP_META_WIDTH  metadata from fetch
- soin_bpredictor_stall  in  1  predictor cannot accept a table write this cycle
- fetch_redirect  out  1  one-cycle redirect pulse
- fetch_redirect_PC  out  32  correct next PC
- execute_bpredictor_update  out  1  table write strobe
- execute_bpredictor_PC / _target  out  32  resolved PC / target of the written entry
- execute_bpredictor_dir / _miss  out  1  outcome / mispredict flag of the written entry
- execute_bpredictor_meta  out  BP_META_WIDTH  repacked meta carrying the new counter in [13:12]
- execute_bpredictor_recover_ras  out  1  RAS restore pulse (uses meta[17:14] in the same cycle)
- drop_count  out  16  saturating count of dropped updates

Behaviour:
- Reset (async) clears stage-1 valid, FIFO pointers and bypass valids. All outputs are 0 during reset and in the first cycle after it.
- Stage 1 (resolution arrives at cycle N, outputs visible at N+1), all registered:
  - miss = (res_p_dir≠res_dir) | (res_dir & res_p_target≠res_target).
  - fetch_redirect = res_valid & miss.
  - fetch_redirect_PC = res_dir ? res_target : res_PC+4 (mod 2^32).
  - execute_bpredictor_recover_ras = res_valid & miss.
  - The restored RAS index is written into the output meta[17:14]: meta RAS index +1 for a call, −1 for a ret, unchanged otherwise (4-bit wrap).
- Counter computation (stage 1):
  - Base counter = newest bypass entry whose index equals meta[11:0], else meta[13:12].
  - New counter = res_dir ? min(base+1,3) : max(base−1,0).
  - Only res_is_cond|res_is_call|res_is_ret with res_valid produce an update. The bypass table is loaded with the accepted (index, new counter) pair, newest-first, in that same cycle.
- FIFO:
  - The stage-1 update is pushed at the end of N+1. The head drives the execute_bpredictor_* outputs combinationally.
  - execute_bpredictor_update = !empty & !soin_bpredictor_stall; pop on the same edge. Minimum latency from res_valid to update is 2 cycles.
  - Push when full and no pop in that cycle: the update is dropped and drop_count increments (saturating at 0xFFFF). The redirect and RAS pulse of that branch are still issued. The bypass table is not loaded for a dropped update.
  - Push and pop in the same cycle with the FIFO full: legal, no drop.
- Back-to-back resolutions: a new resolution is accepted every cycle. Consecutive same-index updates chain through the bypass, e.g. counter 1 taken → 2, taken again → 3, not from stale meta.
- The RAS recover pulse is tied to stage 1 and is not delayed by the FIFO. The RAS index is carried separately on the recover path so the pulse and its index stay coherent.

Decomposition:
- Add BP meta field offsets/widths, the counter saturation limits and the branch-class encodings to soin_header.v, shared with the predictor.
- Sub-module soin_bpredictor_update_fifo: parameterised synchronous FIFO with full/empty, combinational head, async reset.

Test Plan:
- Cond branch at PC 0x1000, p_dir=0, dir=1, target 0x1040, meta counter 1, idx 0x400 → N+1: redirect=1, redirect_PC=0x1040, recover_ras=1; N+2: update=1, meta[13:12]=2, miss=1.
- Correctly predicted not-taken at PC 0x2000, meta counter 0 → no redirect; update with counter 0 (saturated), miss=0.
- Three back-to-back taken resolutions on idx 0x010 with meta counter 0 each → written counters 1, 2, 3.
- Stall held for 6 cycles with 6 resolutions (FIFO_DEPTH=4) → 4 updates queued, drop_count=2, all redirects still emitted; release stall → 4 updates on consecutive cycles in order.
- Mispredicted ret with meta RAS index 5 → recover_ras=1 with meta[17:14]=4; mispredicted call with index 15 → index 0 (wrap).
- Assert reset with 3 entries queued and a redirect pending → outputs 0 immediately; after release, no stale update or redirect appears.
